// File: rtl/seg_ctrl_scan.sv
// Eight-digit multiplexed seven-segment scanner.
// A prescale counter sets how long each digit is shown. A 3-bit index
// then steps through the digits. The digit enables and the segment
// pattern are decoded combinationally from that index, so any change
// on the selected nibble appears on the segments in the same cycle.
module seg_ctrl_scan #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] hex1,
  input  logic [3:0] hex2,
  input  logic [3:0] hex3,
  input  logic [3:0] hex4,
  input  logic [3:0] hex5,
  input  logic [3:0] hex6,
  input  logic [3:0] hex7,
  input  logic [3:0] hex8,
  output logic [6:0] seg_out,
  output logic [7:0] seg_ctrl
);

  // Last count value of one digit dwell.
  localparam logic [23:0] DIV_LAST = 24'(SCAN_DIV - 1);

  logic [23:0] cnt_q;
  logic [23:0] cnt_d;
  logic [2:0]  idx_q;
  logic [2:0]  idx_d;
  logic [3:0]  nib_s;

  // Active-low a..g pattern for one hex nibble (bit0 = a, bit6 = g).
  function automatic logic [6:0] hex_to_seg(input logic [3:0] val);
    logic [6:0] seg;
    case (val)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  // Next-state logic: the counter wraps after the dwell, and the index steps on the same edge.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (cnt_q >= DIV_LAST) begin
      cnt_d = 24'd0;
      idx_d = idx_q + 3'd1;
    end else begin
      cnt_d = cnt_q + 24'd1;
      idx_d = idx_q;
    end
  end

  // Scan state registers. Reset overrides counting and restarts at digit 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 24'd0;
      idx_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  // Select the nibble of the active digit. Unselected inputs are ignored.
  always_comb begin
    nib_s = hex1;
    case (idx_q)
      3'd0:    nib_s = hex1;
      3'd1:    nib_s = hex2;
      3'd2:    nib_s = hex3;
      3'd3:    nib_s = hex4;
      3'd4:    nib_s = hex5;
      3'd5:    nib_s = hex6;
      3'd6:    nib_s = hex7;
      3'd7:    nib_s = hex8;
      default: nib_s = hex1;
    endcase
  end

  // Drive exactly one active-low enable and the pattern for the selected nibble.
  always_comb begin
    seg_ctrl = ~(8'b0000_0001 << idx_q);
    seg_out  = hex_to_seg(nib_s);
  end

endmodule

// File: tb/tb_seg_ctrl_scan.sv
// Directed bench for seg_ctrl_scan. It uses three instances: dwell 4,
// dwell 1, and a long dwell that keeps digit 1 selected.
module tb_seg_ctrl_scan;

  logic       clk;
  logic       reset;
  logic [3:0] hex [8];

  logic [6:0] seg4, seg1, segl;
  logic [7:0] ctl4, ctl1, ctll;

  int errors = 0;
  int checks = 0;

  // Hand-computed decode table, in the order 0..F.
  logic [7:0] dec [16] = '{8'h40, 8'h79, 8'h24, 8'h30, 8'h19, 8'h12, 8'h02, 8'h78,
                           8'h00, 8'h10, 8'h08, 8'h03, 8'h46, 8'h21, 8'h06, 8'h0E};
  // Expected segments for digits 1..8 with hex = A,b,C,d,E,F,7,8.
  logic [7:0] scan_seg [8] = '{8'h08, 8'h03, 8'h46, 8'h21, 8'h06, 8'h0E, 8'h78, 8'h00};

  seg_ctrl_scan #(.SCAN_DIV(4)) dut4 (
    .clk(clk), .reset(reset),
    .hex1(hex[0]), .hex2(hex[1]), .hex3(hex[2]), .hex4(hex[3]),
    .hex5(hex[4]), .hex6(hex[5]), .hex7(hex[6]), .hex8(hex[7]),
    .seg_out(seg4), .seg_ctrl(ctl4));

  seg_ctrl_scan #(.SCAN_DIV(1)) dut1 (
    .clk(clk), .reset(reset),
    .hex1(hex[0]), .hex2(hex[1]), .hex3(hex[2]), .hex4(hex[3]),
    .hex5(hex[4]), .hex6(hex[5]), .hex7(hex[6]), .hex8(hex[7]),
    .seg_out(seg1), .seg_ctrl(ctl1));

  seg_ctrl_scan #(.SCAN_DIV(1000)) dutl (
    .clk(clk), .reset(reset),
    .hex1(hex[0]), .hex2(hex[1]), .hex3(hex[2]), .hex4(hex[3]),
    .hex5(hex[4]), .hex6(hex[5]), .hex7(hex[6]), .hex8(hex[7]),
    .seg_out(segl), .seg_ctrl(ctll));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] one;
    int di;
    reset = 1'b1;
    hex[0] = 4'hA; hex[1] = 4'hB; hex[2] = 4'hC; hex[3] = 4'hD;
    hex[4] = 4'hE; hex[5] = 4'hF; hex[6] = 4'h7; hex[7] = 4'h8;

    // Reset state and decode of hex1.
    step();
    step();
    chk("rst_ctrl", ctl4, 8'hFE);
    chk("rst_seg", {1'b0, seg4}, 8'h08);
    chk("rst_ctrl_div1", ctl1, 8'hFE);
    reset = 1'b0;

    // Free run for 100 cycles: dwell-4 scan over the first 32, one-hot dwell-1 throughout.
    for (int k = 1; k <= 100; k++) begin
      step();
      one = 8'b0000_0001;
      if (k <= 32) begin
        di = (k / 4) % 8;
        chk($sformatf("scan_ctrl_k%0d", k), ctl4, ~(one << di));
        chk($sformatf("scan_seg_k%0d", k), {1'b0, seg4}, scan_seg[di]);
      end
      chk($sformatf("onehot_k%0d", k), 8'($countones(~ctl1)), 8'd1);
      chk($sformatf("order_k%0d", k), ctl1, ~(one << (k % 8)));
    end

    // Long dwell keeps digit 1 selected: sweep hex1 over the full decode.
    chk("long_ctrl", ctll, 8'hFE);
    for (int v = 0; v < 16; v++) begin
      hex[0] = 4'(v);
      #1;
      chk($sformatf("decode_%0h", v), {1'b0, segl}, dec[v]);
      step();
    end

    // Isolation: hex5 must not disturb digit 1.
    hex[0] = 4'h5;
    #1;
    chk("iso_before", {1'b0, segl}, 8'h12);
    hex[4] = 4'h0;
    #1;
    chk("iso_hex5_0", {1'b0, segl}, 8'h12);
    hex[4] = 4'h9;
    #1;
    chk("iso_hex5_9", {1'b0, segl}, 8'h12);
    chk("iso_ctrl", ctll, 8'hFE);

    // Mid-scan reset while digit 5 is active.
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 0; k < 16; k++) step();
    chk("mid_pre_ctrl", ctl4, 8'hEF);
    reset = 1'b1;
    step();
    chk("mid_rst_ctrl", ctl4, 8'hFE);
    reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("mid_dwell_k%0d", k), ctl4, 8'hFE);
    end
    step();
    chk("mid_next_ctrl", ctl4, 8'hFD);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_ctrl_scan.md
SEG_CTRL_SCAN -- requirements
Module: seg_ctrl_scan

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset, named clk and reset.
REQ-002 Parameter SCAN_DIV, default 100000, SHALL set the clk cycles each digit is displayed (1 ms at 100 MHz); legal range 1 to 2^24-1.
REQ-003 Port clk, input, 1 bit: rising-edge system clock.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Ports hex1..hex8, input, 4 bits each: nibble values for digits 1..8.
REQ-006 Port seg_out, output, 7 bits: active-low cathodes; bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g; no decimal point.
REQ-007 Port seg_ctrl, output, 8 bits: active-low digit enables; bit i enables digit i+1, so bit0 enables hex1's digit.

Function
REQ-008 A 24-bit prescale counter cnt SHALL count 0..SCAN_DIV-1, then return to 0 on the next clk edge.
REQ-009 A 3-bit digit index idx SHALL increment on the clk edge where cnt == SCAN_DIV-1, wrapping from 7 to 0.
REQ-010 Each digit SHALL therefore be active for exactly SCAN_DIV cycles; the full scan period is 8*SCAN_DIV cycles.
REQ-011 With SCAN_DIV=1, idx SHALL advance on every clk edge.
REQ-012 seg_ctrl SHALL equal ~(8'b1 << idx) combinationally from idx: exactly one bit low at all times, never zero bits low, never multiple bits low.
REQ-013 seg_out SHALL be the combinational decode of hex(idx+1); a change on the selected hexN input SHALL appear on seg_out in the same cycle.
REQ-014 The decode (hex value -> seg_out) SHALL be: 0->0x40, 1->0x79, 2->0x24, 3->0x30, 4->0x19, 5->0x12, 6->0x02, 7->0x78, 8->0x00, 9->0x10.
REQ-015 The decode SHALL continue: A->0x08, b->0x03, C->0x46, d->0x21, E->0x06, F->0x0E.
REQ-016 Changes on unselected hex inputs SHALL NOT affect any output.
REQ-017 hex inputs SHALL NOT be latched; they are sampled continuously.
REQ-018 The block SHALL contain no latches, and all sequential logic SHALL be on posedge clk.

Reset
REQ-019 While reset is high at a clk edge, cnt SHALL be set to 0 and idx SHALL be set to 0.
REQ-020 After reset, seg_ctrl SHALL be 8'hFE and seg_out SHALL be the decode of hex1.
REQ-021 Reset SHALL take priority over counting.
REQ-022 If reset is asserted mid-scan at any idx, the scan SHALL restart from digit 1 with a full SCAN_DIV dwell.
REQ-023 Before the first reset, outputs SHALL be undefined; the bench SHALL apply reset for at least 1 cycle.

Verification
REQ-024 Scenario, reset and decode: SCAN_DIV=4, hex1..hex8 = A,B,C,D,E,F,7,8; apply reset -> seg_ctrl=8'hFE, seg_out=0x08.
REQ-025 Scenario, dwell and wrap: continuing REQ-024 -> seg_ctrl=8'hFD and seg_out=0x03 after 4 cycles; digits 3..8 give seg_out 0x46, 0x21, 0x06, 0x0E, 0x78, 0x00; 8'hFE returns after 32 cycles.
REQ-026 Scenario, full decode: hold idx at 0 (SCAN_DIV large); sweep hex1 over 0..F -> seg_out matches REQ-014 and REQ-015 in the same cycle.
REQ-027 Scenario, one-hot check: SCAN_DIV=1, run 100 cycles -> seg_ctrl has exactly one zero every cycle and idx visits 0..7 in order.
REQ-028 Scenario, mid-scan reset: SCAN_DIV=4, reset asserted while seg_ctrl=8'hEF -> next edge gives seg_ctrl=8'hFE, followed by a full 4-cycle dwell.
REQ-029 Scenario, isolation: change hex5 while digit 1 is active -> seg_out unchanged.
